dffmem_bus_ctrl: RTL and testbench



---
 rtl/dffmem_pkg.sv | 14 +
 rtl/dffmem_bus_ctrl_if.sv | 26 ++
 rtl/dffmem_addr_decode.sv | 29 ++
 rtl/dffmem_bus_ctrl.sv | 160 ++++++++++++++++
 tb/tb_dffmem_bus_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/dffmem_pkg.sv
// Shared types and constants for the DFF memory bus controller.
//   state_e  : controller FSM states
//   region_e : address-decode result
package dffmem_pkg;

   localparam int ROM_AW    = 3;
   localparam int ROM_WORDS = 8;
   localparam int DATA_W    = 16;

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;

   typedef enum logic [1:0] {REG_ROM, REG_RAM, REG_CTRL, REG_UNMAP} region_e;

endpackage

// File: rtl/dffmem_bus_ctrl_if.sv
// CPU-side request/response handshake bundle.
//   master : CPU (drives request, accepts response)
//   slave  : controller (accepts request, drives response)
interface dffmem_bus_ctrl_if #(
   parameter int ADDR_W = 12
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [15:0]       req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [15:0]       rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dffmem_addr_decode.sv
// Combinational address map.
//   addr       in  ADDR_W  CPU word address
//   boot_remap in  1       1 = boot ROM aliased at the bottom of the map
//   region     out 2       REG_ROM / REG_RAM / REG_CTRL / REG_UNMAP
module dffmem_addr_decode
   import dffmem_pkg::*;
#(
   parameter int                ADDR_W    = 12,
   parameter int                RAM_AW    = 8,
   parameter logic [ADDR_W-1:0] CTRL_ADDR = {ADDR_W{1'b1}}
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic              boot_remap,
   output region_e           region
);

   // Range tests as "no bits above the window", avoiding width games
   // with 2**RAM_AW when RAM_AW approaches ADDR_W.
   always_comb begin
      region = REG_UNMAP;
      if (boot_remap && ((addr >> ROM_AW) == '0))
         region = REG_ROM;
      else if ((addr >> RAM_AW) == '0)
         region = REG_RAM;
      else if (addr == CTRL_ADDR)
         region = REG_CTRL;
   end

endmodule

// File: rtl/dffmem_bus_ctrl.sv
// Single-master bus controller for the 8x16 boot ROM and DFF RAM.
//   clk, rst           : clock, synchronous active-high reset
//   bus (slave)        : CPU valid/ready request + buffered response
//   rom_cs/we/addr/din : boot ROM strobes, rom_dout read data
//   ram_cs/we/addr/din : RAM strobes, ram_dout read data (1-cycle registered)
//   boot_remap         : 1 = ROM mapped at 0 (set by reset, cleared by software)
// One request in flight: IDLE -> ACCESS -> WAIT x RD_LAT -> RESP for reads,
// IDLE -> ACCESS -> RESP for writes, IDLE -> RESP for CTRL/unmapped.
module dffmem_bus_ctrl
   import dffmem_pkg::*;
#(
   parameter int                ADDR_W    = 12,
   parameter int                RAM_AW    = 8,
   parameter logic [ADDR_W-1:0] CTRL_ADDR = 12'hFFF,
   parameter int                RD_LAT    = 1
) (
   input  logic              clk,
   input  logic              rst,
   dffmem_bus_ctrl_if.slave  bus,
   output logic              rom_cs,
   output logic              rom_we,
   output logic [ROM_AW-1:0] rom_addr,
   output logic [15:0]       rom_din,
   input  logic [15:0]       rom_dout,
   output logic              ram_cs,
   output logic              ram_we,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [15:0]       ram_din,
   input  logic [15:0]       ram_dout,
   output logic              boot_remap
);

   localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   state_e      state;
   region_e     dec_region;
   region_e     region_q;
   logic        we_q;
   logic [CNT_W-1:0] cnt;
   logic        req_ready_q;
   logic        rsp_valid_q;
   logic [15:0] rsp_rdata_q;
   logic        rsp_err_q;

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

   // Decode uses the live remap bit, so a CTRL write only affects
   // requests accepted after it.
   dffmem_addr_decode #(
      .ADDR_W    (ADDR_W),
      .RAM_AW    (RAM_AW),
      .CTRL_ADDR (CTRL_ADDR)
   ) u_dec (
      .addr       (bus.req_addr),
      .boot_remap (boot_remap),
      .region     (dec_region)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         region_q    <= REG_UNMAP;
         we_q        <= 1'b0;
         cnt         <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         rom_cs      <= 1'b0;
         rom_we      <= 1'b0;
         rom_addr    <= '0;
         rom_din     <= '0;
         ram_cs      <= 1'b0;
         ram_we      <= 1'b0;
         ram_addr    <= '0;
         ram_din     <= '0;
         boot_remap  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  req_ready_q <= 1'b0;
                  we_q        <= bus.req_we;
                  region_q    <= dec_region;
                  case (dec_region)
                     // Strobes are registered here so they are valid for
                     // the whole ACCESS cycle.
                     REG_ROM: begin
                        rom_cs   <= 1'b1;
                        rom_we   <= bus.req_we;
                        rom_addr <= bus.req_addr[ROM_AW-1:0];
                        rom_din  <= bus.req_wdata;
                        state    <= ACCESS;
                     end
                     REG_RAM: begin
                        ram_cs   <= 1'b1;
                        ram_we   <= bus.req_we;
                        ram_addr <= bus.req_addr[RAM_AW-1:0];
                        ram_din  <= bus.req_wdata;
                        state    <= ACCESS;
                     end
                     REG_CTRL: begin
                        if (bus.req_we) boot_remap <= bus.req_wdata[0];
                        rsp_rdata_q <= bus.req_we ? 16'h0000 : {15'b0, boot_remap};
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                     end
                     default: begin
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                     end
                  endcase
               end
            end
            ACCESS: begin
               rom_we <= 1'b0;
               ram_we <= 1'b0;
               if (we_q) begin
                  rom_cs      <= 1'b0;
                  ram_cs      <= 1'b0;
                  rsp_rdata_q <= '0;
                  rsp_err_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state       <= RESP;
               end else begin
                  cnt   <= CNT_W'(RD_LAT - 1);
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  rsp_rdata_q <= (region_q == REG_ROM) ? rom_dout : ram_dout;
                  rsp_err_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rom_cs      <= 1'b0;
                  ram_cs      <= 1'b0;
                  state       <= RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dffmem_bus_ctrl.sv
// Scoreboard bench for dffmem_bus_ctrl with behavioural ROM/RAM models.
module tb_dffmem_bus_ctrl;
   import dffmem_pkg::*;

   localparam int RD_LAT = 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dffmem_bus_ctrl_if #(.ADDR_W(12)) bus ();

   logic        rom_cs, rom_we, ram_cs, ram_we, boot_remap;
   logic [2:0]  rom_addr;
   logic [7:0]  ram_addr;
   logic [15:0] rom_din, rom_dout, ram_din, ram_dout;

   dffmem_bus_ctrl #(.ADDR_W(12), .RAM_AW(8), .CTRL_ADDR(12'hFFF), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .rom_cs(rom_cs), .rom_we(rom_we), .rom_addr(rom_addr), .rom_din(rom_din), .rom_dout(rom_dout),
      .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
      .boot_remap(boot_remap)
   );

   // standalone decoder
   logic [11:0] dec_addr;
   logic        dec_remap;
   region_e     dec_region;
   dffmem_addr_decode #(.ADDR_W(12), .RAM_AW(8), .CTRL_ADDR(12'hFFF)) u_dec (
      .addr(dec_addr), .boot_remap(dec_remap), .region(dec_region)
   );

   // Boot ROM: registered read, only word 7 is writable.
   logic [15:0] rom_mem [8];
   logic [15:0] ram_mem [256];
   initial begin
      rom_mem[0] = 16'hF200; rom_mem[1] = 16'h4000; rom_mem[2] = 16'h0000; rom_mem[3] = 16'h0000;
      rom_mem[4] = 16'hB007; rom_mem[5] = 16'h0000; rom_mem[6] = 16'h0000; rom_mem[7] = 16'h0008;
      for (int i = 0; i < 256; i++) ram_mem[i] = 16'h0000;
   end
   always @(posedge clk) begin
      if (rom_cs && rom_we && rom_addr == 3'd7) rom_mem[7] <= rom_din;
      rom_dout <= rom_mem[rom_addr];
      if (ram_cs && ram_we) ram_mem[ram_addr] <= ram_din;
      ram_dout <= ram_mem[ram_addr];
   end

   int pass_cnt = 0;
   int total_cnt = 0;
   int rsp_count = 0;
   int rom_cs_n = 0, ram_cs_n = 0, we_n = 0;
   string cur_name = "";
   logic [16:0] exp_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s [%s]: got %0h expected %0h", name, cur_name, act, exp);
   endtask

   task automatic fail_now(input string name);
      total_cnt++;
      $display("FAIL %s [%s]: timeout", name, cur_name);
   endtask

   // strobe activity counters
   always @(negedge clk) begin
      if (rom_cs) rom_cs_n++;
      if (ram_cs) ram_cs_n++;
      if (rom_we || ram_we) we_n++;
   end

   // monitor: pop and compare on every response handshake
   always @(negedge clk) begin
      if (!rst && bus.rsp_valid && bus.rsp_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_rsp", 32'(bus.rsp_rdata), 32'hFFFF_FFFF);
         end else begin
            logic [16:0] e;
            e = exp_q.pop_front();
            check("rsp_rdata", 32'(bus.rsp_rdata), 32'(e[15:0]));
            check("rsp_err", 32'(bus.rsp_err), 32'(e[16]));
         end
         rsp_count++;
      end
   end

   task automatic do_req(input string name, input logic we, input logic [11:0] addr,
                         input logic [15:0] wdata, input logic [15:0] exp_rdata, input logic exp_err,
                         input int exp_rom, input int exp_ram);
      int t, lat, seen, exp_lat;
      cur_name = name;
      @(posedge clk); #1;
      t = 0;
      while (!bus.req_ready && t < 50) begin @(posedge clk); #1; t++; end
      if (!bus.req_ready) fail_now("req_ready");
      rom_cs_n = 0; ram_cs_n = 0; we_n = 0;
      bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wdata;
      exp_q.push_back({exp_err, exp_rdata});
      seen = rsp_count;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
      exp_lat = (exp_rom + exp_ram == 0) ? 1 : (we ? 2 : 2 + RD_LAT);
      check("rsp_latency", 32'(lat), 32'(exp_lat));
      @(posedge clk); #1;
      if (rsp_count == seen) fail_now("rsp_handshake");
      check("rom_cs_cycles", 32'(rom_cs_n), 32'(exp_rom));
      check("ram_cs_cycles", 32'(ram_cs_n), 32'(exp_ram));
      check("we_cycles", 32'(we_n), (we && (exp_rom + exp_ram) != 0) ? 32'd1 : 32'd0);
   endtask

   typedef struct { logic [11:0] a; logic r; region_e reg_e; } dec_vec_t;
   dec_vec_t dvec [8];

   initial begin
      int t;
      logic [15:0] held;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
      bus.rsp_ready = 1'b1;
      dec_addr = '0; dec_remap = 1'b0;
      rst = 1'b1;

      // decoder address map
      dvec[0] = '{12'h000, 1'b1, REG_ROM};   dvec[1] = '{12'h007, 1'b1, REG_ROM};
      dvec[2] = '{12'h008, 1'b1, REG_RAM};   dvec[3] = '{12'h000, 1'b0, REG_RAM};
      dvec[4] = '{12'h0FF, 1'b1, REG_RAM};   dvec[5] = '{12'h100, 1'b1, REG_UNMAP};
      dvec[6] = '{12'hFFF, 1'b0, REG_CTRL};  dvec[7] = '{12'h800, 1'b1, REG_UNMAP};
      cur_name = "decode";
      for (int i = 0; i < 8; i++) begin
         dec_addr = dvec[i].a; dec_remap = dvec[i].r; #1;
         check("decode_region", 32'(dec_region), 32'(dvec[i].reg_e));
      end

      repeat (3) @(posedge clk);
      #1;
      cur_name = "reset";
      check("rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
      check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      check("rst_boot_remap", 32'(boot_remap), 32'd1);
      check("rst_strobes", {28'd0, rom_cs, rom_we, ram_cs, ram_we}, 32'd0);
      check("rst_addrs", {21'd0, rom_addr, ram_addr}, 32'd0);
      rst = 1'b0;

      do_req("rd rom 0x000", 1'b0, 12'h000, 16'h0000, 16'hF200, 1'b0, 1 + RD_LAT, 0);
      do_req("rd rom 0x004", 1'b0, 12'h004, 16'h0000, 16'hB007, 1'b0, 1 + RD_LAT, 0);
      do_req("rd rom 0x007", 1'b0, 12'h007, 16'h0000, 16'h0008, 1'b0, 1 + RD_LAT, 0);
      do_req("wr rom 0x007", 1'b1, 12'h007, 16'h1234, 16'h0000, 1'b0, 1, 0);
      do_req("rd rom 0x007b", 1'b0, 12'h007, 16'h0000, 16'h1234, 1'b0, 1 + RD_LAT, 0);

      // backpressure on a ROM read with a second request queued behind it
      cur_name = "backpressure";
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 12'h001;
      exp_q.push_back({1'b0, 16'h4000});
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      t = 0;
      while (!bus.rsp_valid && t < 50) begin @(posedge clk); #1; t++; end
      if (!bus.rsp_valid) fail_now("bp_rsp_valid");
      held = bus.rsp_rdata;
      check("bp_rdata", 32'(held), 32'h4000);
      bus.req_valid = 1'b1; bus.req_addr = 12'h004;
      exp_q.push_back({1'b0, 16'hB007});
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("bp_valid_held", 32'(bus.rsp_valid), 32'd1);
         check("bp_rdata_held", 32'(bus.rsp_rdata), 32'h4000);
         check("bp_req_ready", 32'(bus.req_ready), 32'd0);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_ready_after", 32'(bus.req_ready), 32'd1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      check("bp_second_accepted", 32'(bus.req_ready), 32'd0);
      t = 0;
      while (exp_q.size() != 0 && t < 50) begin @(posedge clk); #1; t++; end
      if (exp_q.size() != 0) fail_now("bp_second_rsp");

      do_req("rd unmapped 0x800", 1'b0, 12'h800, 16'h0000, 16'h0000, 1'b1, 0, 0);
      do_req("wr unmapped 0x900", 1'b1, 12'h900, 16'hBEEF, 16'h0000, 1'b1, 0, 0);
      do_req("rd ctrl 1", 1'b0, 12'hFFF, 16'h0000, 16'h0001, 1'b0, 0, 0);
      do_req("wr ctrl 1", 1'b1, 12'hFFF, 16'h0001, 16'h0000, 1'b0, 0, 0);
      check("remap_still_1", 32'(boot_remap), 32'd1);
      do_req("wr ctrl 0", 1'b1, 12'hFFF, 16'h0000, 16'h0000, 1'b0, 0, 0);
      do_req("rd ctrl 0", 1'b0, 12'hFFF, 16'h0000, 16'h0000, 1'b0, 0, 0);
      check("remap_cleared", 32'(boot_remap), 32'd0);
      do_req("wr ram 0x000", 1'b1, 12'h000, 16'hABCD, 16'h0000, 1'b0, 0, 1);
      do_req("rd ram 0x000", 1'b0, 12'h000, 16'h0000, 16'hABCD, 1'b0, 0, 1 + RD_LAT);
      do_req("wr ram 0x0FF", 1'b1, 12'h0FF, 16'h5A5A, 16'h0000, 1'b0, 0, 1);
      do_req("rd ram 0x0FF", 1'b0, 12'h0FF, 16'h0000, 16'h5A5A, 1'b0, 0, 1 + RD_LAT);

      // reset while a RAM read sits in WAIT: no response, remap restored
      cur_name = "reset mid-wait";
      @(posedge clk); #1;
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 12'h005;
      @(posedge clk); #1;   // ACCESS
      bus.req_valid = 1'b0;
      @(posedge clk); #1;   // WAIT
      check("wait_ram_cs", 32'(ram_cs), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("abort_cs", {30'd0, rom_cs, ram_cs}, 32'd0);
      check("abort_req_ready", 32'(bus.req_ready), 32'd1);
      check("abort_boot_remap", 32'(boot_remap), 32'd1);
      repeat (3) begin
         @(posedge clk); #1;
         check("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
      end
      do_req("rd rom after rst", 1'b0, 12'h000, 16'h0000, 16'hF200, 1'b0, 1 + RD_LAT, 0);

      cur_name = "end";
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
